// File: rtl/vram_sprite_animator.sv
// vram_sprite_animator
//
// Moves a square sprite around a VRAM-backed frame. The sprite is drawn, held for
// PERIOD enabled cycles, erased, then moved one pixel diagonally. The move either
// wraps around the frame (MODE=0) or bounces off its edges (MODE=1). During a draw
// or erase phase, one pixel is written per cycle in row-major order.
//
// Ports
//   CLK        clock; all logic runs on its rising edge
//   RST_X      asynchronous active-low reset
//   EN         enables the wait timer; a phase that has started always completes
//   MODE       0 = wrap-around, 1 = bounce; sampled in the move cycle
//   COLOR      sprite colour, latched at the first pixel of a draw
//   BGCOLOR    erase colour, latched at the first pixel of an erase
//   VRAM_ADDR  write address {y, x}
//   VRAM_DATA  write data {1'b0, colour}
//   VRAM_WE    write strobe, one pixel per cycle
//   BUSY       high while drawing, erasing or moving
//   POS_X/Y    top-left corner of the sprite
module vram_sprite_animator #(
    parameter int unsigned XW     = 7,
    parameter int unsigned YW     = 7,
    parameter int unsigned XMAX   = 127,
    parameter int unsigned YMAX   = 127,
    parameter int unsigned SIZE   = 4,
    parameter int unsigned PERIOD = 8388608
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             EN,
    input  logic             MODE,
    input  logic [2:0]       COLOR,
    input  logic [2:0]       BGCOLOR,
    output logic [YW+XW-1:0] VRAM_ADDR,
    output logic [3:0]       VRAM_DATA,
    output logic             VRAM_WE,
    output logic             BUSY,
    output logic [XW-1:0]    POS_X,
    output logic [YW-1:0]    POS_Y
);

    localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [1:0] StDraw  = 2'd0;
    localparam logic [1:0] StWait  = 2'd1;
    localparam logic [1:0] StErase = 2'd2;
    localparam logic [1:0] StMove  = 2'd3;

    localparam logic [XW-1:0] XOne  = XW'(1);
    localparam logic [YW-1:0] YOne  = YW'(1);
    localparam logic [TW-1:0] TOne  = TW'(1);
    localparam logic [XW-1:0] XMaxC = XW'(XMAX);
    localparam logic [YW-1:0] YMaxC = YW'(YMAX);
    localparam logic [XW-1:0] XLast = XW'(SIZE - 1);
    localparam logic [YW-1:0] YLast = YW'(SIZE - 1);
    // Largest position at which the whole sprite still fits on screen.
    localparam logic [XW-1:0] XLim  = XW'(XMAX - SIZE + 1);
    localparam logic [YW-1:0] YLim  = YW'(YMAX - SIZE + 1);
    localparam logic [TW-1:0] TLast = TW'(PERIOD - 1);

    // (a + b) mod (MAX+1) for a, b <= MAX, computed without a carry bit so that a
    // non-power-of-two frame still wraps correctly at the native width.
    function automatic logic [XW-1:0] wrap_add_x(input logic [XW-1:0] a,
                                                 input logic [XW-1:0] b);
        logic [XW-1:0] room;
        room = XMaxC - a;
        if (b > room) return b - room - XOne;
        return a + b;
    endfunction

    function automatic logic [YW-1:0] wrap_add_y(input logic [YW-1:0] a,
                                                 input logic [YW-1:0] b);
        logic [YW-1:0] room;
        room = YMaxC - a;
        if (b > room) return b - room - YOne;
        return a + b;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [XW-1:0]    px_q, px_d;
    logic [YW-1:0]    py_q, py_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [XW-1:0]    pos_x_q, pos_x_d;
    logic [YW-1:0]    pos_y_q, pos_y_d;
    logic             x_dec_q, x_dec_d;   // 1 = moving towards 0
    logic             y_dec_q, y_dec_d;
    logic [2:0]       col_q, col_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;
    logic [YW+XW-1:0] addr_q, addr_d;
    logic [3:0]       data_q, data_d;
    logic             first_pix;
    logic [2:0]       pix_col;

    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        timer_d   = timer_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        x_dec_d   = x_dec_q;
        y_dec_d   = y_dec_q;
        col_d     = col_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        first_pix = (px_q == '0) && (py_q == '0);
        pix_col   = col_q;

        case (state_q)
            StDraw, StErase: begin
                // The colour is taken live on the first pixel and held from then on.
                if (first_pix) pix_col = (state_q == StDraw) ? COLOR : BGCOLOR;
                col_d  = pix_col;
                we_d   = 1'b1;
                data_d = {1'b0, pix_col};
                addr_d = {wrap_add_y(pos_y_q, py_q), wrap_add_x(pos_x_q, px_q)};
                if (px_q == XLast) begin
                    px_d = '0;
                    if (py_q == YLast) begin
                        py_d    = '0;
                        state_d = (state_q == StDraw) ? StWait : StMove;
                    end else begin
                        py_d = py_q + YOne;
                    end
                end else begin
                    px_d = px_q + XOne;
                end
            end

            StWait: begin
                if (EN) begin
                    if (timer_q == TLast) begin
                        timer_d = '0;
                        state_d = StErase;
                    end else begin
                        timer_d = timer_q + TOne;
                    end
                end
            end

            StMove: begin
                state_d = StDraw;
                if (!MODE) begin
                    if (x_dec_q) pos_x_d = (pos_x_q == '0) ? XMaxC : pos_x_q - XOne;
                    else         pos_x_d = (pos_x_q == XMaxC) ? '0 : pos_x_q + XOne;
                    if (y_dec_q) pos_y_d = (pos_y_q == '0) ? YMaxC : pos_y_q - YOne;
                    else         pos_y_d = (pos_y_q == YMaxC) ? '0 : pos_y_q + YOne;
                end else begin
                    // A sprite left hanging over the edge by wrap mode restarts at 0.
                    if (pos_x_q > XLim) begin
                        pos_x_d = '0;
                        x_dec_d = 1'b0;
                    end else if (!x_dec_q) begin
                        if (pos_x_q == XLim) begin
                            x_dec_d = 1'b1;
                            pos_x_d = pos_x_q - XOne;
                        end else begin
                            pos_x_d = pos_x_q + XOne;
                        end
                    end else if (pos_x_q == '0) begin
                        x_dec_d = 1'b0;
                        pos_x_d = pos_x_q + XOne;
                    end else begin
                        pos_x_d = pos_x_q - XOne;
                    end

                    if (pos_y_q > YLim) begin
                        pos_y_d = '0;
                        y_dec_d = 1'b0;
                    end else if (!y_dec_q) begin
                        if (pos_y_q == YLim) begin
                            y_dec_d = 1'b1;
                            pos_y_d = pos_y_q - YOne;
                        end else begin
                            pos_y_d = pos_y_q + YOne;
                        end
                    end else if (pos_y_q == '0) begin
                        y_dec_d = 1'b0;
                        pos_y_d = pos_y_q + YOne;
                    end else begin
                        pos_y_d = pos_y_q - YOne;
                    end
                end
            end

            default: state_d = StDraw;
        endcase

        // BUSY stays high through the last write of a draw, so it never drops while
        // VRAM_WE is still asserted.
        busy_d = we_d | (state_d != StWait);
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= StDraw;
            px_q    <= '0;
            py_q    <= '0;
            timer_q <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            x_dec_q <= 1'b0;
            y_dec_q <= 1'b0;
            col_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            timer_q <= timer_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            x_dec_q <= x_dec_d;
            y_dec_q <= y_dec_d;
            col_q   <= col_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign VRAM_ADDR = addr_q;
    assign VRAM_DATA = data_q;
    assign VRAM_WE   = we_q;
    assign BUSY      = busy_q;
    assign POS_X     = pos_x_q;
    assign POS_Y     = pos_y_q;

endmodule

// File: tb/tb_vram_sprite_animator.sv
// Directed bench for vram_sprite_animator on an 8x8 frame with a 2x2 sprite and a
// 5-cycle wait period.
module tb_vram_sprite_animator;

    logic       CLK = 1'b0;
    logic       RST_X = 1'b0;
    logic       EN = 1'b0;
    logic       MODE = 1'b0;
    logic [2:0] COLOR = 3'd7;
    logic [2:0] BGCOLOR = 3'd0;
    logic [5:0] VRAM_ADDR;
    logic [3:0] VRAM_DATA;
    logic       VRAM_WE;
    logic       BUSY;
    logic [2:0] POS_X;
    logic [2:0] POS_Y;

    int n_cmp = 0;
    int n_err = 0;

    vram_sprite_animator #(
        .XW(3), .YW(3), .XMAX(7), .YMAX(7), .SIZE(2), .PERIOD(5)
    ) dut (
        .CLK(CLK), .RST_X(RST_X), .EN(EN), .MODE(MODE), .COLOR(COLOR),
        .BGCOLOR(BGCOLOR), .VRAM_ADDR(VRAM_ADDR), .VRAM_DATA(VRAM_DATA),
        .VRAM_WE(VRAM_WE), .BUSY(BUSY), .POS_X(POS_X), .POS_Y(POS_Y)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic mode;
        int   ex;
        int   ey;
    } move_vec_t;

    move_vec_t mv[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Checks the four writes of one phase at sprite corner (x0, y0).
    task automatic chk_phase(input string tag, input int x0, input int y0,
                             input logic [3:0] dat);
        for (int py = 0; py < 2; py++) begin
            for (int px = 0; px < 2; px++) begin
                @(negedge CLK);
                chk({tag, " we"}, VRAM_WE, 1);
                chk({tag, " addr"}, VRAM_ADDR, (((y0 + py) % 8) << 3) | ((x0 + px) % 8));
                chk({tag, " data"}, VRAM_DATA, dat);
            end
        end
    endtask

    // Waits for the erase to begin and then for the move cycle that follows it.
    task automatic wait_move(output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (!(VRAM_WE && VRAM_DATA == 4'h0) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) return;
        n = 0;
        while (VRAM_WE && n < 10) begin
            @(negedge CLK);
            n++;
        end
        ok = (n < 10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n;
        int viol;
        logic [5:0] wrap_addr [4];

        mv[0]  = '{1'b0, 2, 2};
        mv[1]  = '{1'b0, 3, 3};
        mv[2]  = '{1'b0, 4, 4};
        mv[3]  = '{1'b0, 5, 5};
        mv[4]  = '{1'b0, 6, 6};
        mv[5]  = '{1'b0, 7, 7};
        mv[6]  = '{1'b0, 0, 0};
        mv[7]  = '{1'b1, 1, 1};
        mv[8]  = '{1'b1, 2, 2};
        mv[9]  = '{1'b1, 3, 3};
        mv[10] = '{1'b1, 4, 4};
        mv[11] = '{1'b1, 5, 5};
        mv[12] = '{1'b1, 6, 6};
        mv[13] = '{1'b1, 5, 5};
        mv[14] = '{1'b1, 4, 4};
        mv[15] = '{1'b1, 3, 3};
        mv[16] = '{1'b1, 2, 2};
        mv[17] = '{1'b1, 1, 1};
        mv[18] = '{1'b1, 0, 0};
        mv[19] = '{1'b1, 1, 1};
        wrap_addr[0] = 6'o77;
        wrap_addr[1] = 6'o70;
        wrap_addr[2] = 6'o07;
        wrap_addr[3] = 6'o00;

        // Reset state.
        repeat (3) @(negedge CLK);
        chk("rst we", VRAM_WE, 0);
        chk("rst addr", VRAM_ADDR, 0);
        chk("rst data", VRAM_DATA, 0);
        chk("rst busy", BUSY, 0);
        chk("rst pos_x", POS_X, 0);
        chk("rst pos_y", POS_Y, 0);

        // First draw after release, then idle in WAIT.
        RST_X = 1'b1;
        chk_phase("draw00", 0, 0, 4'h7);
        @(negedge CLK);
        chk("wait we", VRAM_WE, 0);
        chk("wait busy", BUSY, 0);

        // Two enabled cycles, a long hold, then three more enabled cycles reach the
        // end of the period; the first erase write follows one cycle later.
        EN = 1'b1;
        repeat (2) @(negedge CLK);
        EN = 1'b0;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (VRAM_WE || BUSY) viol++;
        end
        chk("hold idle", viol, 0);
        EN = 1'b1;
        n = 0;
        while (!VRAM_WE && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("erase latency", n, 4);
        chk("erase0 addr", VRAM_ADDR, 0);
        chk("erase0 data", VRAM_DATA, 0);
        for (int k = 1; k < 4; k++) begin
            @(negedge CLK);
            chk("erase we", VRAM_WE, 1);
            chk("erase addr", VRAM_ADDR, ((k / 2) << 3) | (k % 2));
            chk("erase data", VRAM_DATA, 0);
        end
        @(negedge CLK);
        chk("move we", VRAM_WE, 0);
        chk("move busy", BUSY, 1);
        chk("move pos_x", POS_X, 1);
        chk("move pos_y", POS_Y, 1);
        chk_phase("draw11", 1, 1, 4'h7);

        // Wrap-mode moves up to the bottom-right corner.
        for (int i = 0; i < 6; i++) begin
            MODE = mv[i].mode;
            wait_move(ok);
            chk("move seen", ok, 1);
            chk("tbl pos_x", POS_X, mv[i].ex);
            chk("tbl pos_y", POS_Y, mv[i].ey);
            chk("tbl busy", BUSY, 1);
        end

        // Draw at (7,7) wraps on both axes.
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("wrap77 we", VRAM_WE, 1);
            chk("wrap77 addr", VRAM_ADDR, wrap_addr[k]);
        end

        // Wrap back to the origin, then bounce across the frame and back.
        for (int i = 6; i < 20; i++) begin
            MODE = mv[i].mode;
            wait_move(ok);
            chk("move seen", ok, 1);
            chk("tbl pos_x", POS_X, mv[i].ex);
            chk("tbl pos_y", POS_Y, mv[i].ey);
            chk("tbl busy", BUSY, 1);
        end

        // Reset during the third erase write.
        n = 0;
        while (!(VRAM_WE && VRAM_DATA == 4'h0) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("erase seen", n < 100, 1);
        repeat (2) @(negedge CLK);
        chk("erase3 we", VRAM_WE, 1);
        RST_X = 1'b0;
        #1;
        chk("abort we", VRAM_WE, 0);
        chk("abort busy", BUSY, 0);
        chk("abort pos_x", POS_X, 0);
        chk("abort addr", VRAM_ADDR, 0);
        @(negedge CLK);
        chk("abort hold we", VRAM_WE, 0);
        RST_X = 1'b1;
        chk_phase("redraw00", 0, 0, 4'h7);
        @(negedge CLK);
        chk("redraw wait we", VRAM_WE, 0);
        chk("redraw wait busy", BUSY, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vram_sprite_animator.md
VRAM_SPRITE_ANIMATOR -- requirements
Module: vram_sprite_animator

Interface
REQ-001 SHALL have parameter XW, default 7, the x-coordinate width in bits.
REQ-002 SHALL have parameter YW, default 7, the y-coordinate width in bits.
REQ-003 SHALL have parameter XMAX, default 127, the last valid column; legal range 1..2^XW-1.
REQ-004 SHALL have parameter YMAX, default 127, the last valid row; legal range 1..2^YW-1.
REQ-005 SHALL have parameter SIZE, default 4, the sprite side in pixels; legal range 1..min(XMAX,YMAX).
REQ-006 SHALL have parameter PERIOD, default 8388608, the enabled WAIT cycles between moves; legal range PERIOD >= 1.
REQ-007 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port RST_X, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port EN, input, 1 bit: enables the WAIT timer.
REQ-010 SHALL have port MODE, input, 1 bit: 0 = wrap-around, 1 = bounce.
REQ-011 SHALL have port COLOR, input, 3 bits: sprite colour.
REQ-012 SHALL have port BGCOLOR, input, 3 bits: erase colour.
REQ-013 SHALL have port VRAM_ADDR, output, YW+XW bits: write address {y, x}.
REQ-014 SHALL have port VRAM_DATA, output, 4 bits: write data {1'b0, colour}.
REQ-015 SHALL have port VRAM_WE, output, 1 bit: VRAM write strobe, one pixel per cycle.
REQ-016 SHALL have port BUSY, output, 1 bit: high in DRAW, ERASE and MOVE.
REQ-017 SHALL have ports POS_X (XW bits) and POS_Y (YW bits), outputs: the sprite's top-left corner.

Function
REQ-018 SHALL drive every output from a register.
REQ-019 SHALL implement the states DRAW, WAIT, ERASE and MOVE.
REQ-020 SHALL make the transitions DRAW->WAIT, WAIT->ERASE, ERASE->MOVE and MOVE->DRAW.
REQ-021 SHALL, in DRAW and in ERASE, issue exactly SIZE*SIZE writes on consecutive cycles (VRAM_WE=1), in row-major order: px is the inner loop 0..SIZE-1 and py the outer loop.
REQ-022 SHALL address each write as x = (POS_X+px) mod (XMAX+1), y = (POS_Y+py) mod (YMAX+1).
REQ-023 SHALL write {0, COLOR} in DRAW and {0, BGCOLOR} in ERASE; each colour is latched on phase entry and held for the whole phase.
REQ-024 SHALL keep VRAM_WE=0 in WAIT and in MOVE.
REQ-025 SHALL make the write for pixel k of a phase visible at the k-th rising edge after phase entry.
REQ-026 SHALL, in WAIT, increment the timer only while EN=1, hold it while EN=0, and go to ERASE (clearing the timer) when timer = PERIOD-1 and EN=1.
REQ-027 SHALL keep MOVE to one cycle, sample MODE in MOVE, and update POS_X and POS_Y together.
REQ-028 SHALL, with MODE=0 (wrap), set POS_X to (POS_X + DX) mod (XMAX+1), with DX = +/-1; POS_Y likewise with DY and YMAX.
REQ-029 SHALL, with MODE=1 (bounce) and DX=+1: if POS_X+SIZE-1 = XMAX, set DX to -1 and decrement POS_X; otherwise increment POS_X.
REQ-030 SHALL, with MODE=1 (bounce) and DX=-1: if POS_X = 0, set DX to +1 and increment POS_X; otherwise decrement POS_X.
REQ-031 SHALL apply the REQ-029/REQ-030 bounce rules to y with DY, POS_Y and YMAX.
REQ-032 SHALL, when MODE switches to bounce while the sprite extends past XMAX or YMAX, force the position on that axis to 0 and the direction to +1 at that MOVE.
REQ-033 SHALL, when EN falls during DRAW, ERASE or MOVE, complete the sequence and stop only in WAIT.
REQ-034 SHALL perform all position and address arithmetic at width XW or YW, and reduce modulo XMAX+1 or YMAX+1 with no wider intermediate visible.

Reset
REQ-035 SHALL, while RST_X=0, immediately force:
- VRAM_WE=0, VRAM_ADDR=0, VRAM_DATA=0, BUSY=0
- POS_X=0, POS_Y=0, DX=+1, DY=+1
- timer=0, px=0, py=0, state=DRAW
REQ-036 SHALL, after release, start DRAW of the sprite at (0,0) on the first rising edge, with BUSY=1.
REQ-037 SHALL, on reset assertion mid-phase, abort the phase with no further writes; the partially drawn pixels are left in VRAM.

Verification
Bench parameters: SIZE=2, PERIOD=5, XMAX=7, YMAX=7, XW=YW=3 unless noted.
REQ-038 SHALL cover: release reset with COLOR=7 -> 4 writes in 4 cycles to addresses {0,0},{0,1},{1,0},{1,1}, data 4'h7, then WAIT with BUSY=0.
REQ-039 SHALL cover: EN=1, MODE=0, BGCOLOR=0 -> 5 WAIT cycles, 4 erase writes of 4'h0 at (0,0), 1 MOVE cycle, then 4 draws at (1,1); POS_X=POS_Y=1.
REQ-040 SHALL cover: MODE=0 with the sprite at (7,7) -> draw addresses wrap to {7,7},{7,0},{0,7},{0,0}; the next move gives position (0,0).
REQ-041 SHALL cover: MODE=1 with the sprite at (6,6), DX=DY=+1 -> next position (5,5) and DX=DY=-1; from (0,0) with DX=DY=-1 -> next position (1,1) and DX=DY=+1.
REQ-042 SHALL cover: EN=0 for 20 cycles in WAIT, then EN=1 -> timer holds its value, and ERASE starts exactly PERIOD enabled cycles after WAIT entry.
REQ-043 SHALL cover: RST_X low during the 3rd ERASE write -> VRAM_WE=0 immediately; after release, DRAW at (0,0) resumes as in REQ-038.
